// File: rtl/mem_tester_multi.sv
// mem_tester_multi: SRAM soak tester. Every pass writes a generated pattern
// over addresses 0..ADDR_LAST through a req/ack memory port, then reads the
// range back and compares it one cycle after each read ack. Odd passes are
// inverted. Pass and error counters saturate.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              run passes while high (a running pass always completes)
//   mode[1:0]           0 LFSR, 1 address, 2 checkerboard, 3 walking one
//   stop_on_err         halt on the first mismatching word
//   mem_req/rnw/addr/wdat, mem_ack, mem_rdat   memory request port
//   busy, halted        FSM status
//   pass_cnt, err_cnt   completed passes, mismatching words
//   led                 blink phase, inverted once any error has been seen
//
// Optional: define ERR_LOG_EN to add err_valid/err_addr/err_exp/err_got,
// holding the first mismatch seen after reset.
module mem_tester_multi #(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       ADDR_W    = 19,
   parameter logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}},
   parameter logic [31:0]       SEED      = 32'h1,
   parameter int unsigned       CNT_W     = 16,
   parameter int unsigned       LED_DIV   = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic              stop_on_err,
   output logic              mem_req,
   output logic              mem_rnw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdat,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdat,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [CNT_W-1:0]  err_cnt,
`ifdef ERR_LOG_EN
   output logic              err_valid,
   output logic [ADDR_W-1:0] err_addr,
   output logic [DATA_W-1:0] err_exp,
   output logic [DATA_W-1:0] err_got,
`endif
   output logic              led
);

   localparam int unsigned       LED_W     = LED_DIV + 1;
   localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
   localparam logic [DATA_W-1:0] CHK_PAT   = DATA_W'({(DATA_W + 1) / 2 {2'b01}});

   typedef enum logic [2:0] {
      S_IDLE, S_WR_START, S_WRITE, S_RD_START, S_READ, S_DRAIN, S_PASS_DONE, S_HALT
   } state_t;

   // Galois right-shift step
   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return {1'b0, l[31:1]} ^ (l[0] ? LFSR_TAPS : 32'h0);
   endfunction

   // Data word for one address of the current pass
   function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                 input logic [ADDR_W-1:0] a,
                                                 input logic [31:0]       l,
                                                 input logic              inv);
      logic [DATA_W-1:0] p;
      case (m)
         2'd0:    p = l[DATA_W-1:0];
         2'd1:    p = DATA_W'(a);
         2'd2:    p = a[0] ? ~CHK_PAT : CHK_PAT;
         default: p = DATA_W'(1) << (32'(a) % DATA_W);
      endcase
      return p ^ {DATA_W{inv}};
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         lfsr_q, lfsr_d;
   logic [31:0]         lfsr_sv_q, lfsr_sv_d;
   logic                inv_q, inv_d;
   logic [1:0]          mode_q, mode_d;
   logic                cmp_vld_q, cmp_vld_d;
   logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
   logic [DATA_W-1:0]   cmp_got_q, cmp_got_d;
   logic [DATA_W-1:0]   pat_q, pat_d;
   logic                pass_inc_c;
   logic                mismatch_c;
   logic                was_error_q;
   logic [LED_W-1:0]    ledcnt_q;
`ifdef ERR_LOG_EN
   logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
`endif

   assign mem_addr   = addr_q;
   assign mismatch_c = cmp_vld_q && (cmp_exp_q != cmp_got_q);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state and datapath next values
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      lfsr_d     = lfsr_q;
      lfsr_sv_d  = lfsr_sv_q;
      inv_d      = inv_q;
      mode_d     = mode_q;
      cmp_vld_d  = 1'b0;
      cmp_exp_d  = cmp_exp_q;
      cmp_got_d  = cmp_got_q;
      pass_inc_c = 1'b0;
`ifdef ERR_LOG_EN
      cmp_addr_d = cmp_addr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_WR_START;
               mode_d  = mode;
            end
         end
         S_WR_START: begin
            addr_d    = '0;
            lfsr_sv_d = lfsr_q;
            state_d   = S_WRITE;
         end
         S_WRITE: begin
            if (mem_ack) begin
               lfsr_d = lfsr_step(lfsr_q);
               if (addr_q == ADDR_LAST) state_d = S_RD_START;
               else                     addr_d  = addr_q + ADDR_W'(1);
            end
         end
         S_RD_START: begin
            // replay the write sequence for the read-back
            addr_d  = '0;
            lfsr_d  = lfsr_sv_q;
            state_d = S_READ;
         end
         S_READ: begin
            if (mem_ack) begin
               cmp_vld_d = 1'b1;
               cmp_exp_d = pat_q;
               cmp_got_d = mem_rdat;
`ifdef ERR_LOG_EN
               cmp_addr_d = addr_q;
`endif
               lfsr_d = lfsr_step(lfsr_q);
               if (addr_q == ADDR_LAST) state_d = S_DRAIN;
               else                     addr_d  = addr_q + ADDR_W'(1);
            end
         end
         S_DRAIN: state_d = S_PASS_DONE;
         S_PASS_DONE: begin
            pass_inc_c = 1'b1;
            inv_d      = ~inv_q;
            if (enable) begin
               state_d = S_WR_START;
               mode_d  = mode;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      // a failing compare wins over any other transition
      if (mismatch_c && stop_on_err) state_d = S_HALT;
   end

   // Pattern for the beat presented after the next edge
   always_comb begin
      pat_d = pattern(mode_d, addr_d, lfsr_d, inv_d);
   end

   // Datapath, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         lfsr_q      <= SEED;
         lfsr_sv_q   <= SEED;
         inv_q       <= 1'b0;
         mode_q      <= '0;
         cmp_vld_q   <= 1'b0;
         cmp_exp_q   <= '0;
         cmp_got_q   <= '0;
         pat_q       <= '0;
         mem_req     <= 1'b0;
         mem_rnw     <= 1'b0;
         mem_wdat    <= '0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         pass_cnt    <= '0;
         err_cnt     <= '0;
         was_error_q <= 1'b0;
         ledcnt_q    <= '0;
         led         <= 1'b0;
      end else begin
         addr_q    <= addr_d;
         lfsr_q    <= lfsr_d;
         lfsr_sv_q <= lfsr_sv_d;
         inv_q     <= inv_d;
         mode_q    <= mode_d;
         cmp_vld_q <= cmp_vld_d;
         cmp_exp_q <= cmp_exp_d;
         cmp_got_q <= cmp_got_d;
         pat_q     <= pat_d;
         mem_req   <= (state_d == S_WRITE) || (state_d == S_READ);
         mem_rnw   <= (state_d == S_READ);
         mem_wdat  <= (state_d == S_WRITE) ? pat_d : '0;
         busy      <= (state_d != S_IDLE) && (state_d != S_HALT);
         halted    <= (state_d == S_HALT);
         if (pass_inc_c && (pass_cnt != {CNT_W{1'b1}}))
            pass_cnt <= pass_cnt + CNT_W'(1);
         if (mismatch_c && (err_cnt != {CNT_W{1'b1}}))
            err_cnt <= err_cnt + CNT_W'(1);
         if (mismatch_c)
            was_error_q <= 1'b1;
         // blank period restarts at each pass boundary and parks once bit LED_DIV sets
         if (state_q == S_PASS_DONE)
            ledcnt_q <= '0;
         else if (!ledcnt_q[LED_DIV])
            ledcnt_q <= ledcnt_q + LED_W'(1);
         led <= ledcnt_q[LED_DIV] ^ was_error_q;
      end
   end

`ifdef ERR_LOG_EN
   // First-mismatch capture; later mismatches are not logged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_addr_q <= '0;
         err_valid  <= 1'b0;
         err_addr   <= '0;
         err_exp    <= '0;
         err_got    <= '0;
      end else begin
         cmp_addr_q <= cmp_addr_d;
         if (mismatch_c && !err_valid) begin
            err_valid <= 1'b1;
            err_addr  <= cmp_addr_q;
            err_exp   <= cmp_exp_q;
            err_got   <= cmp_got_q;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_tester_multi.sv
// Bench for mem_tester_multi (16-word range, 8-bit data). Expected memory
// beats are queued per pass; a negedge monitor plays the memory, acks beats
// (optionally after random stalls) and checks each beat against the queue.
module tb_mem_tester_multi;

   localparam int unsigned DW   = 8;
   localparam int unsigned AW   = 4;
   localparam int unsigned CW   = 16;
   localparam int unsigned LD   = 3;
   localparam logic [31:0] SEED = 32'h1;

   typedef struct packed {
      logic          rnw;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [1:0]    mode;
   logic          stop_on_err;
   logic          mem_req, mem_rnw;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdat;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdat = '0;
   logic          busy, halted, led;
   logic [CW-1:0] pass_cnt, err_cnt;
`ifdef ERR_LOG_EN
   logic          err_valid;
   logic [AW-1:0] err_addr;
   logic [DW-1:0] err_exp, err_got;
`endif

   beat_t         exp_q[$];
   logic [DW-1:0] mem [16];
   logic [31:0]   m_lfsr;
   bit            fault = 1'b0;
   int            stall_max = 0;
   int            stall = 0;
   int            cyc = 0;
   int            beat_cnt = 0, t_first = 0, t_last = 0, t_bad = -1;
   int            total = 0, bad = 0;
   int            n, t_halt;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_tester_multi #(
      .DATA_W(DW), .ADDR_W(AW), .ADDR_LAST(4'hF), .SEED(SEED),
      .CNT_W(CW), .LED_DIV(LD)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode),
      .stop_on_err(stop_on_err),
      .mem_req(mem_req), .mem_rnw(mem_rnw), .mem_addr(mem_addr),
      .mem_wdat(mem_wdat), .mem_ack(mem_ack), .mem_rdat(mem_rdat),
      .busy(busy), .halted(halted), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
`ifdef ERR_LOG_EN
      .err_valid(err_valid), .err_addr(err_addr),
      .err_exp(err_exp), .err_got(err_got),
`endif
      .led(led)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] lstep(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [7:0] pat(input int m, input int a, input logic [31:0] l, input bit inv);
      logic [7:0]  p;
      logic [31:0] av;
      av = 32'(a);
      case (m)
         0:       p = l[7:0];
         1:       p = av[7:0];
         2:       p = av[0] ? 8'hAA : 8'h55;
         default: p = 8'h01 << (a % 8);
      endcase
      return inv ? ~p : p;
   endfunction

   // Queue the 16 writes and 16 reads of pass number k
   task automatic push_pass(input int m, input int k);
      logic [31:0] s;
      beat_t       b;
      s = m_lfsr;
      for (int a = 0; a < 16; a++) begin
         b = {1'b0, 4'(a), pat(m, a, s, (k % 2) == 1)};
         exp_q.push_back(b);
         s = lstep(s);
      end
      for (int a = 0; a < 16; a++) begin
         b = {1'b1, 4'(a), 8'h00};
         exp_q.push_back(b);
      end
      m_lfsr = s;
   endtask

   task automatic reset_on();
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      beat_cnt = 0;
      t_bad    = -1;
      m_lfsr   = SEED;
      repeat (2) @(negedge clk);
   endtask

   // Let pass 'target' reach its read phase, drop enable, wait for IDLE
   task automatic drop_in_read(input int target, input string tag);
      int k;
      k = 0;
      while (!(mem_req && mem_rnw && pass_cnt == 16'(target - 1)) && k < 6000) begin
         @(negedge clk);
         k++;
      end
      enable = 1'b0;
      k = 0;
      while (busy && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(target));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Memory model and beat monitor
   always @(negedge clk) begin
      beat_t got, e;
      mem_ack = 1'b0;
      if (rst) begin
         stall = 0;
      end else if (mem_req) begin
         got = {mem_rnw, mem_addr, mem_rnw ? 8'h00 : mem_wdat};
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected got=0x%0h expected=none", got);
         end else if (stall > 0) begin
            stall--;
            chk("beat_hold", 32'(got), 32'(exp_q[0]));
         end else begin
            e = exp_q.pop_front();
            chk("beat", 32'(got), 32'(e));
            mem_ack = 1'b1;
            beat_cnt++;
            if (beat_cnt == 1) t_first = cyc;
            t_last = cyc;
            if (!mem_rnw) begin
               mem[mem_addr] = mem_wdat;
            end else begin
               if (fault && mem[mem_addr][3] && t_bad < 0) t_bad = cyc + 1;
               mem_rdat = fault ? (mem[mem_addr] & 8'hF7) : mem[mem_addr];
            end
            stall = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      rst = 1'b1; enable = 1'b0; mode = 2'd0; stop_on_err = 1'b0;
      m_lfsr = SEED;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_mem_req",  32'(mem_req),  0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdat", 32'(mem_wdat), 0);
      chk("rst_busy",     32'(busy),     0);
      chk("rst_halted",   32'(halted),   0);
      chk("rst_pass_cnt", 32'(pass_cnt), 0);
      chk("rst_err_cnt",  32'(err_cnt),  0);
      chk("rst_led",      32'(led),      0);
`ifdef ERR_LOG_EN
      chk("rst_err_valid", 32'(err_valid), 0);
`endif

      // address-as-data, ideal memory, enable dropped during pass 1 read
      mode = 2'd1;
      push_pass(1, 0);
      enable = 1'b1;
      rst = 1'b0;
      drop_in_read(1, "addr1");
      chk("addr1_err_cnt", 32'(err_cnt), 0);
      chk("addr1_beats",   32'(beat_cnt), 32);
      chk("addr1_span",    32'(t_last - t_first), 32);
      chk("addr1_q_empty", 32'(exp_q.size()), 0);
      repeat (3) @(negedge clk);
      chk("idle_stays", 32'(busy), 0);
      push_pass(1, 1);
      enable = 1'b1;
      drop_in_read(2, "addr2");
      chk("addr2_mem0",    32'(mem[0]),  32'hFF);
      chk("addr2_mem5",    32'(mem[5]),  32'hFA);
      chk("addr2_mem15",   32'(mem[15]), 32'hF0);
      chk("addr2_err_cnt", 32'(err_cnt), 0);
      chk("addr2_q_empty", 32'(exp_q.size()), 0);

      // bit 3 stuck at 0, walking one, keep running
      reset_on();
      fault = 1'b1; mode = 2'd3; stop_on_err = 1'b0;
      push_pass(3, 0);
      push_pass(3, 1);
      enable = 1'b1;
      rst = 1'b0;
      n = 0;
      while (pass_cnt != 16'd1 && n < 2000) begin @(negedge clk); n++; end
      chk("stuck_p1_err_cnt", 32'(err_cnt), 2);
      chk("stuck_p1_halted",  32'(halted),  0);
      drop_in_read(2, "stuck2");
      chk("stuck_p2_err_cnt", 32'(err_cnt), 16);

      // asynchronous reset in the middle of the write phase
      push_pass(3, 2);
      enable = 1'b1;
      n = 0;
      while (!(mem_req && !mem_rnw && mem_addr == 4'd7) && n < 400) begin @(negedge clk); n++; end
      #2 rst = 1'b1;
      #1;
      chk("arst_mem_req",  32'(mem_req),  0);
      chk("arst_pass_cnt", 32'(pass_cnt), 0);
      chk("arst_err_cnt",  32'(err_cnt),  0);
      chk("arst_busy",     32'(busy),     0);
      @(negedge clk);
      exp_q.delete();
      beat_cnt = 0;
      m_lfsr = SEED;
      fault = 1'b0; mode = 2'd0;
      push_pass(0, 0);
      @(negedge clk);
      rst = 1'b0;
      drop_in_read(1, "lfsr_restart");
      chk("lfsr_restart_err", 32'(err_cnt), 0);
      chk("lfsr_restart_q",   32'(exp_q.size()), 0);

      // LFSR patterns with random ack stalls, ten more passes
      stall_max = 3;
      for (int k = 1; k <= 10; k++) push_pass(0, k);
      enable = 1'b1;
      drop_in_read(11, "stall");
      stall_max = 0;
      chk("stall_err_cnt", 32'(err_cnt), 0);
      chk("stall_q_empty", 32'(exp_q.size()), 0);

      // stop on the first mismatch
      reset_on();
      fault = 1'b1; mode = 2'd3; stop_on_err = 1'b1;
      push_pass(3, 0);
      enable = 1'b1;
      rst = 1'b0;
      n = 0;
      while (!(mem_req && mem_rnw) && n < 200) begin @(negedge clk); n++; end
      chk("stop_led_before", 32'(led), 1);
      n = 0;
      while (!halted && n < 200) begin @(negedge clk); n++; end
      t_halt = cyc;
      chk("stop_latency", 32'((t_bad > 0) && (t_halt - t_bad >= 1) && (t_halt - t_bad <= 2)), 1);
      chk("stop_halted",   32'(halted),   1);
      chk("stop_mem_req",  32'(mem_req),  0);
      chk("stop_busy",     32'(busy),     0);
      chk("stop_err_cnt",  32'(err_cnt),  1);
      chk("stop_pass_cnt", 32'(pass_cnt), 0);
      repeat (6) @(negedge clk);
      chk("stop_led_after",  32'(led),     0);
      chk("stop_halt_holds", 32'(halted),  1);
      chk("stop_req_holds",  32'(mem_req), 0);
`ifdef ERR_LOG_EN
      chk("log_valid", 32'(err_valid), 1);
      chk("log_addr",  32'(err_addr),  3);
      chk("log_exp",   32'(err_exp),   32'h08);
      chk("log_got",   32'(err_got),   32'h00);
`endif
      enable = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
